// File: rtl/i2s_mic_rx.sv
// I2S master receiver for one microphone: derives bclk/ws from clk and delivers
// each left-slot word as a raw 32-bit sample with a one-cycle valid pulse.
module i2s_mic_rx #(
   parameter int CLK_DIV        = 8,
   parameter int DISCARD_FRAMES = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        enable,
   input  logic        i2s_sd,
   output logic        i2s_bclk,
   output logic        i2s_ws,
   output logic [31:0] sample_out,
   output logic        sample_valid,
   output logic        running
);

   typedef enum logic [1:0] {OFF, SYNC, RUN} state_t;

   localparam logic [7:0] DIV_LAST  = 8'(CLK_DIV - 1);
   localparam logic [7:0] DISCARD_N = 8'(DISCARD_FRAMES);

   state_t      state;
   state_t      state_next;
   logic [1:0]  rst_pipe;
   logic        go;
   logic [7:0]  div_cnt;
   logic        div_tc;
   logic        bclk_rise;
   logic        bclk_fall;
   logic [5:0]  bit_cnt;
   logic [5:0]  bit_next;
   logic        frame_wrap;
   logic [7:0]  discard_cnt;
   logic [1:0]  sd_pipe;
   logic [31:0] shift;
   logic        word_done;

   // Reset release is re-timed so the state machine never leaves OFF on a partial clock edge.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) rst_pipe <= 2'b00;
      else        rst_pipe <= {rst_pipe[0], 1'b1};
   end

   assign go         = enable & rst_pipe[1];
   assign div_tc     = (state != OFF) && (div_cnt == DIV_LAST);
   assign bclk_rise  = div_tc && !i2s_bclk;
   assign bclk_fall  = div_tc && i2s_bclk;
   assign bit_next   = bit_cnt + 6'd1;
   assign frame_wrap = bclk_fall && (bit_cnt == 6'd63);
   assign running    = (state == RUN);

   always_comb begin
      state_next = state;
      case (state)
         OFF: begin
            if (go) state_next = (DISCARD_FRAMES == 0) ? RUN : SYNC;
         end
         SYNC: begin
            if (!go)                                        state_next = OFF;
            else if (frame_wrap && discard_cnt == DISCARD_N) state_next = RUN;
         end
         RUN: begin
            if (!go) state_next = OFF;
         end
         default: state_next = OFF;
      endcase
   end

   // Leaving the run request clears the whole timing chain so a restart begins a fresh frame.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state        <= OFF;
         sd_pipe      <= 2'b00;
         div_cnt      <= 8'd0;
         i2s_bclk     <= 1'b0;
         i2s_ws       <= 1'b1;
         bit_cnt      <= 6'd63;
         discard_cnt  <= 8'd0;
         shift        <= 32'd0;
         word_done    <= 1'b0;
         sample_out   <= 32'd0;
         sample_valid <= 1'b0;
      end else begin
         state        <= state_next;
         sd_pipe      <= {sd_pipe[0], i2s_sd};
         sample_valid <= 1'b0;
         word_done    <= 1'b0;
         if (!go || state == OFF) begin
            div_cnt     <= 8'd0;
            i2s_bclk    <= 1'b0;
            i2s_ws      <= 1'b1;
            bit_cnt     <= 6'd63;
            discard_cnt <= 8'd0;
            shift       <= 32'd0;
         end else begin
            div_cnt <= div_tc ? 8'd0 : div_cnt + 8'd1;
            if (div_tc) i2s_bclk <= ~i2s_bclk;
            if (bclk_fall) begin
               bit_cnt <= bit_next;
               i2s_ws  <= bit_next[5];
            end
            if (frame_wrap && state == SYNC) discard_cnt <= discard_cnt + 8'd1;
            // Slot bit 0 is the one-bit I2S delay, so the left word occupies bits 1..32.
            if (bclk_rise && bit_cnt >= 6'd1 && bit_cnt <= 6'd32) begin
               shift     <= {shift[30:0], sd_pipe[1]};
               word_done <= (bit_cnt == 6'd32);
            end
            if (word_done && state == RUN) begin
               sample_out   <= shift;
               sample_valid <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_i2s_mic_rx.sv
// Bench for i2s_mic_rx: two instances (no discard, four-frame discard) driven by
// behavioural I2S microphones and checked against a frame-level timing model.
`timescale 1ns/1ps
module tb_i2s_mic_rx;

   localparam int CD    = 8;
   localparam int FRAME = 128 * CD;

   typedef struct {
      logic [31:0] left;
      logic [31:0] expect_out;
   } vec_t;

   logic        clk   = 1'b0;
   logic        reset = 1'b0;
   logic        en [2];
   logic [31:0] words [2][64];
   int          cyc   = 0;
   int          total = 0;
   int          bad   = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   for (genvar g = 0; g < 2; g++) begin : lane
      logic        sd = 1'b1;
      logic        bclk;
      logic        ws;
      logic        valid;
      logic        running;
      logic [31:0] sample;
      logic [31:0] cur_word;
      int          pos = 99;
      int          frame = 0;
      logic        bclk_prev = 1'b0;
      logic        ws_prev = 1'b1;
      logic        valid_prev = 1'b0;
      logic        run_prev = 1'b0;
      int          pulse_n = 0;
      int          pulse_cyc [64];
      logic [31:0] pulse_val [64];
      int          wide = 0;
      int          run_rise = -1;
      int          phase_len = 0;
      int          bclk_bad = 0;
      int          ws_low = 0;
      int          ws_bad = 0;

      i2s_mic_rx #(.CLK_DIV(CD), .DISCARD_FRAMES(g == 0 ? 0 : 4)) dut (
         .clk(clk), .reset(reset), .enable(en[g]), .i2s_sd(sd),
         .i2s_bclk(bclk), .i2s_ws(ws), .sample_out(sample),
         .sample_valid(valid), .running(running));

      // Microphone: new frame on ws falling; drives the left word MSB first one bit after ws, right slot all ones.
      initial forever begin
         @(negedge clk);
         if (bclk_prev && !bclk) begin
            if (!ws && ws_prev) begin
               pos   = 0;
               frame = frame + 1;
            end else begin
               pos = pos + 1;
            end
            cur_word = words[g][frame % 64];
            sd = (pos >= 1 && pos <= 32) ? cur_word[32 - pos] : 1'b1;
         end
         if (!running) begin
            phase_len = 0;
            ws_low    = 0;
         end else begin
            if (bclk != bclk_prev) begin
               if (phase_len != CD) bclk_bad = bclk_bad + 1;
               phase_len = 0;
            end
            phase_len = phase_len + 1;
            if (ws != ws_prev && !(bclk_prev && !bclk)) ws_bad = ws_bad + 1;
            if (ws && !ws_prev) begin
               if (ws_low != 64 * CD) ws_bad = ws_bad + 1;
               ws_low = 0;
            end
            if (!ws) ws_low = ws_low + 1;
         end
         if (valid) begin
            if (valid_prev) wide = wide + 1;
            pulse_cyc[pulse_n % 64] = cyc;
            pulse_val[pulse_n % 64] = sample;
            pulse_n = pulse_n + 1;
         end
         if (running && !run_prev) run_rise = cyc;
         bclk_prev  = bclk;
         ws_prev    = ws;
         valid_prev = valid;
         run_prev   = running;
      end
   end

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      total++;
      if (actual !== expected) begin
         bad++;
         $display("[TB] FAIL %s: got %h want %h", name, actual, expected);
      end
   endtask

   task automatic waitCycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic applyStimulus(input int g, input logic value);
      @(negedge clk);
      en[g] = value;
   endtask

   function automatic int pulseCount(input int g);
      return (g == 0) ? lane[0].pulse_n : lane[1].pulse_n;
   endfunction

   function automatic logic [31:0] pulseVal(input int g, input int i);
      return (g == 0) ? lane[0].pulse_val[i % 64] : lane[1].pulse_val[i % 64];
   endfunction

   function automatic int pulseCyc(input int g, input int i);
      return (g == 0) ? lane[0].pulse_cyc[i % 64] : lane[1].pulse_cyc[i % 64];
   endfunction

   // Model: frame k's ws falls 2*CD after the enable edge plus k frames; its word lands 65*CD+1 later.
   function automatic int pulseCycle(input int e, input int k);
      return e + 2 * CD + k * FRAME + 65 * CD + 1;
   endfunction

   task automatic waitPulses(input int g, input int target, input int budget);
      int n;
      n = pulseCount(g);
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         n = pulseCount(g);
         if (n >= target) return;
      end
      checkOutput("pulse wait", n, target);
   endtask

   task automatic waitPos(input int g, input int p, input int budget);
      int cur;
      cur = -1;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         cur = (g == 0) ? lane[0].pos : lane[1].pos;
         if (cur == p) return;
      end
      checkOutput("slot position wait", cur, p);
   endtask

   task automatic runDiscard(input string tag, output int b, output int p0);
      int e;
      b  = lane[1].frame;
      p0 = lane[1].pulse_n;
      for (int k = 0; k < 8; k++) words[1][(b + 1 + k) % 64] = $urandom;
      applyStimulus(1, 1'b1);
      e = cyc + 1;
      waitPulses(1, p0 + 2, 8 * FRAME);
      checkOutput({tag, " running rise"}, lane[1].run_rise, e + 2 * CD + 4 * FRAME);
      for (int k = 0; k < 2; k++) begin
         checkOutput($sformatf("%s value %0d", tag, k), pulseVal(1, p0 + k), words[1][(b + 5 + k) % 64]);
         checkOutput($sformatf("%s time %0d", tag, k), pulseCyc(1, p0 + k), pulseCycle(e, 4 + k));
      end
   endtask

   initial begin
      vec_t        vecs [16];
      int          e;
      int          b;
      int          p0;
      int          pn;
      logic [31:0] last;

      en[0] = 1'b0;
      en[1] = 1'b0;
      for (int g = 0; g < 2; g++)
         for (int i = 0; i < 64; i++) words[g][i] = 32'd0;

      waitCycles(3);
      checkOutput("reset bclk", lane[0].bclk, 32'd0);
      checkOutput("reset ws", lane[0].ws, 32'd1);
      checkOutput("reset sample", lane[0].sample, 32'd0);
      checkOutput("reset valid", lane[0].valid, 32'd0);
      checkOutput("reset running", lane[1].running, 32'd0);

      for (int k = 0; k < 16; k++) begin
         if (k < 2)       vecs[k].left = 32'hA5C3_F000;
         else if (k < 12) vecs[k].left = 32'h100 * (k - 1);
         else             vecs[k].left = $urandom;
         vecs[k].expect_out = vecs[k].left;
      end
      b = lane[0].frame;
      for (int k = 0; k < 16; k++) words[0][(b + 1 + k) % 64] = vecs[k].left;

      // Enable is already high at reset release; the release itself is re-timed by two flops.
      @(negedge clk);
      reset = 1'b1;
      en[0] = 1'b1;
      e = cyc + 3;
      waitCycles(2);
      checkOutput("sync hold", lane[0].running, 32'd0);
      waitCycles(1);
      checkOutput("sync release", lane[0].running, 32'd1);

      waitPulses(0, 16, 17 * FRAME);
      for (int k = 0; k < 16; k++) begin
         checkOutput($sformatf("capture value %0d", k), pulseVal(0, k), vecs[k].expect_out);
         checkOutput($sformatf("capture time %0d", k), pulseCyc(0, k), pulseCycle(e, k));
      end
      checkOutput("valid width", lane[0].wide, 32'd0);
      checkOutput("bclk half period", lane[0].bclk_bad, 32'd0);
      checkOutput("ws shape", lane[0].ws_bad, 32'd0);

      waitPos(0, 10, 2 * FRAME);
      #2;
      reset = 1'b0;
      #1;
      checkOutput("async bclk", lane[0].bclk, 32'd0);
      checkOutput("async ws", lane[0].ws, 32'd1);
      checkOutput("async sample", lane[0].sample, 32'd0);
      checkOutput("async valid", lane[0].valid, 32'd0);
      checkOutput("async running", lane[0].running, 32'd0);
      en[0] = 1'b0;
      waitCycles(4);
      reset = 1'b1;
      waitCycles(4);

      b  = lane[0].frame;
      p0 = lane[0].pulse_n;
      words[0][(b + 1) % 64] = $urandom;
      words[0][(b + 2) % 64] = $urandom;
      applyStimulus(0, 1'b1);
      e = cyc + 1;
      waitPulses(0, p0 + 2, 3 * FRAME);
      for (int k = 0; k < 2; k++) begin
         checkOutput($sformatf("restart value %0d", k), pulseVal(0, p0 + k), words[0][(b + 1 + k) % 64]);
         checkOutput($sformatf("restart time %0d", k), pulseCyc(0, p0 + k), pulseCycle(e, k));
      end

      runDiscard("discard", b, p0);
      waitPos(1, 20, 2 * FRAME);
      en[1] = 1'b0;
      pn   = lane[1].pulse_n;
      last = words[1][(b + 5 + (pn - p0) - 1) % 64];
      @(negedge clk);
      checkOutput("drop bclk", lane[1].bclk, 32'd0);
      checkOutput("drop ws", lane[1].ws, 32'd1);
      checkOutput("drop running", lane[1].running, 32'd0);
      waitCycles(2 * FRAME);
      checkOutput("drop no pulse", lane[1].pulse_n, pn);
      checkOutput("drop sample held", lane[1].sample, last);

      runDiscard("rediscard", b, p0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog: simulation did not reach its end");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule

// File: doc/i2s_mic_rx.md
# i2s_mic_rx

I2S master receiver that sits directly upstream of the FFT system top. It generates the microphone bit clock and word-select from the 48 MHz system clock and deserialises the microphone's left-channel slot into 32-bit words. Each completed word is delivered as `sample_out` with a one-cycle `sample_valid` pulse, which drive the FFT input buffer's `sample_in` and `sample_valid`.

## Interface
- `CLK_DIV`, default 8: `clk` cycles per bclk half-period. Legal range is 4..255. Default gives bclk = 3 MHz and a 46.875 kHz frame rate.
- `DISCARD_FRAMES`, default 4: number of complete frames thrown away after `enable` rises, covering microphone startup. Legal range is 0..255.
- `clk`  in  1  48 MHz HFOSC system clock; the only clock.
- `reset`  in  1  asynchronous, active-low reset. 0 = reset asserted.
- `enable`  in  1  run request, level-sensitive.
- `i2s_sd`  in  1  serial data from the microphone; asynchronous to `clk`.
- `i2s_bclk`  out  1  bit clock to the microphone (registered).
- `i2s_ws`  out  1  word select. 0 = left slot, 1 = right slot (registered).
- `sample_out`  out  32  last complete left-slot word, MSB first as received; held between pulses.
- `sample_valid`  out  1  one-`clk` pulse when `sample_out` updates.
- `running`  out  1  high in RUN state.

## Operation
- **State machine:**
  - OFF: bclk held 0, ws held 1, counters cleared.
  - OFF → SYNC when `enable` = 1.
  - SYNC → RUN at the end of frame number DISCARD_FRAMES. If DISCARD_FRAMES = 0, go straight to RUN with no frame discarded.
  - SYNC or RUN → OFF on the first cycle with `enable` = 0.
- **Clock generation:**
  - `div_cnt` counts 0..CLK_DIV-1.
  - At terminal count, `i2s_bclk` toggles and `div_cnt` wraps to 0.
  - In OFF, `div_cnt` = 0 and bclk = 0.
  - The first rising bclk edge occurs CLK_DIV cycles after entering SYNC.
- **Bit counter and word select:**
  - `bit_cnt` is 6 bits. Reset/OFF value is 63.
  - It increments (wrapping 63 → 0) in the same cycle bclk falls.
  - `i2s_ws` is registered as the new `bit_cnt[5]`, so ws changes only on falling bclk.
  - One frame = bit_cnt 0..63 = 128·CLK_DIV `clk` cycles.
- **Data input:**
  - `i2s_sd` passes through a 2-flop synchroniser.
  - The synchronised bit is sampled in the cycle bclk rises.
- **Capture (standard I2S, one-bit delay):**
  - Rising edges with bit_cnt = 1..32 shift the sampled bit into a 32-bit shift register at the LSB end.
  - bit_cnt 1 carries the word MSB; bit_cnt 32 carries the LSB.
  - The right slot (bit_cnt 33..63 and 0) is never captured.
- **Word completion:**
  - After the bit_cnt = 32 shift, in RUN, `sample_out` is loaded with the shift register contents and `sample_valid` = 1 on the next `clk` edge.
  - In SYNC the completed word is discarded: no load, no pulse.
- **Discard counting:** the discard counter increments on each bit_cnt 63 → 0 wrap while in SYNC.
- **Data handling:** the 32 bits are passed raw. No sign extension or masking; the microphone's 24-bit data sits in bits 31:8.
- **Reset values:** `i2s_bclk`=0, `i2s_ws`=1, `sample_out`=0, `sample_valid`=0, `running`=0, state = OFF, discard counter = 0.

## Timing
- **`sample_valid` width:** exactly 1 `clk` cycle.
- **`sample_valid` spacing:** exactly 128·CLK_DIV cycles in steady RUN (1024 cycles at default).
- **Latency:** `sample_valid` rises 1 `clk` after the rising-bclk cycle of bit_cnt 32, i.e. (65·CLK_DIV + 1) cycles after the falling edge that set ws = 0.
- **`sample_out` stability:** changes only together with `sample_valid`; unaffected by `enable` low.
- **Sampling margin:** `i2s_sd` has a full half-period (CLK_DIV cycles) from the falling edge to sampling, of which the synchroniser consumes 2. This is why CLK_DIV ≥ 4.
- **`enable` dropped mid-frame:**
  - Next cycle: bclk = 0, ws = 1, bit_cnt = 63, discard counter = 0, `running` = 0.
  - The partial word is lost and no pulse is produced.
  - If `enable` = 0 in the same cycle a word completes, no pulse is produced.
- **`enable` reasserted:** re-enters SYNC and performs the full discard again.
- **`reset` asserted:** takes effect immediately, mid-frame or otherwise, and all outputs go to their reset values. Release is synchronised internally (2-flop) before state leaves OFF.

## Test plan
- **Basic capture:** `reset`, then `enable`=1, CLK_DIV=8, DISCARD_FRAMES=0; bench mic model drives left word 0xA5C3_F000 and right word 0xFFFF_FFFF each frame → first `sample_valid` at the frame-0 bit-32 capture; `sample_out`=0xA5C3F000 every pulse; no right data leaks.
- **Pulse periodicity:** 10 consecutive frames with incrementing left words 0x0000_0100..0x0000_0A00 → pulses exactly 1024 cycles apart, each 1 cycle wide, values in order.
- **Discard:** DISCARD_FRAMES=4 → no pulse during frames 0..3; first pulse in frame 4; `running` rises at the frame 3 → 4 wrap.
- **Clock shapes:** bclk period 16 cycles at 50% duty; ws toggles only on falling bclk, period 1024 cycles, low for bit_cnt 0..31.
- **Enable drop:** drop `enable` at bit_cnt 20 → no pulse; bclk=0 and ws=1 on the next cycle; `sample_out` retains the prior value. Re-enable → full discard again.
- **Async reset:** assert `reset`=0 mid-word (bit_cnt 10) → all outputs at reset values without waiting for a `clk` edge; clean restart after release.
